// File: rtl/timedisk_ctrl_mc.sv
// TimeDisk multi-channel slot-card controller: NCH auto-stepping RAM-disk
// pointer channels, a ROM bank register and the IOSEL/IOSTRB expansion-ROM
// enable, sitting between the 6502 slot bus and the shared SRAM/ROM pins.
module timedisk_ctrl_mc #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned BANK_W = 7
) (
  input  logic              C7M,
  input  logic              RES,
  input  logic              PHI1,
  input  logic [15:0]       A,
  input  logic              nWE,
  input  logic              nDEVSEL,
  input  logic              nIOSEL,
  input  logic              nIOSTRB,
  input  logic [7:0]        D_in,
  output logic [7:0]        D_out,
  output logic              D_oe,
  input  logic [7:0]        RD_in,
  output logic [7:0]        RD_out,
  output logic              RD_oe,
  output logic [ADDR_W-1:0] RA,
  input  logic              RAMROMCSgb,
  output logic              nRAMROMCS,
  output logic              RAMCS,
  output logic              nROMCS
);

  localparam int unsigned HI_W   = ADDR_W - 16;
  localparam int unsigned MODE_W = 2 * NCH;

  logic              phi1r1_q, phi1r2_q;
  logic              regen_q, regen_d;
  logic              ioromen_q, ioromen_d;
  logic              dsel_vld_q, dsel_vld_d;
  logic [1:0]        dsel_ch_q, dsel_ch_d;
  logic              dsel_rd_q, dsel_rd_d;
  logic [ADDR_W-1:0] ptr_q [NCH];
  logic [ADDR_W-1:0] ptr_d [NCH];
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [BANK_W-1:0] bank_q, bank_d;

  logic              csdben, step, latch, wr;
  logic [1:0]        ch;
  logic              chan_ok, regsel, datsel, romsel;
  logic [ADDR_W-1:0] ptr_sel, ra_rom;
  logic [BANK_W+11:0] rom_addr;
  logic [7:0]        hi_rb, rb;
  logic              unused_a;

  // Phase events derived from PHI1 and its two C7M-delayed copies
  assign csdben = ~phi1r2_q;
  assign step   = PHI1 & ~phi1r1_q;
  assign latch  = ~PHI1 & ~phi1r1_q & phi1r2_q;
  assign wr     = ~PHI1 & ~phi1r1_q & ~phi1r2_q;

  assign ch       = A[3:2];
  assign chan_ok  = (32'(ch) < NCH);
  assign regsel   = ~nDEVSEL & regen_q;
  assign datsel   = regsel & chan_ok & (A[1:0] == 2'd3);
  assign romsel   = ~nIOSEL | (~nIOSTRB & ioromen_q);
  assign unused_a = ^A[15:12];

  // Register readback and address selection for the addressed channel
  always_comb begin
    ptr_sel = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (ch == 2'(c)) ptr_sel = ptr_q[c];
    end
    hi_rb = '1;
    hi_rb[HI_W-1:0] = ptr_sel[ADDR_W-1:16];
    rb = '0;
    if (chan_ok) begin
      case (A[1:0])
        2'd0:    rb = ptr_sel[7:0];
        2'd1:    rb = ptr_sel[15:8];
        2'd2:    rb = hi_rb;
        default: rb = '0;
      endcase
    end else if (A[3:0] == 4'hC) begin
      rb[MODE_W-1:0] = mode_q;
    end else if (A[3:0] == 4'hF) begin
      rb[BANK_W-1:0] = bank_q;
    end
    rom_addr = {bank_q, A[11:0]};
    // size cast both truncates and zero-pads to the pointer width
    ra_rom   = ADDR_W'(rom_addr);
  end

  // Next-state: LATCH captures selects, WR loads registers, STEP moves pointer
  always_comb begin
    regen_d    = regen_q;
    ioromen_d  = ioromen_q;
    dsel_vld_d = dsel_vld_q;
    dsel_ch_d  = dsel_ch_q;
    dsel_rd_d  = dsel_rd_q;
    ptr_d      = ptr_q;
    mode_d     = mode_q;
    bank_d     = bank_q;
    if (latch) begin
      dsel_vld_d = datsel;
      dsel_ch_d  = ch;
      dsel_rd_d  = nWE;
      if (~nIOSEL) regen_d = 1'b1;
      if (~nIOSTRB && (A[11:0] == 12'hFFF)) ioromen_d = 1'b0;
      else if (~nIOSEL && (A[7:0] == 8'h00)) ioromen_d = 1'b1;
    end
    if (wr && ~nWE && regsel) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (ch == 2'(c)) begin
          case (A[1:0])
            2'd0:    ptr_d[c][7:0]        = D_in;
            2'd1:    ptr_d[c][15:8]       = D_in;
            2'd2:    ptr_d[c][ADDR_W-1:16] = D_in[HI_W-1:0];
            default: ;
          endcase
        end
      end
      if (A[3:0] == 4'hC) mode_d = D_in[MODE_W-1:0];
      if (A[3:0] == 4'hF) bank_d = D_in[BANK_W-1:0];
    end
    if (step && dsel_vld_q) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (dsel_ch_q == 2'(c)) begin
          case (mode_q[2*c +: 2])
            2'b01:   ptr_d[c] = ptr_q[c] + ADDR_W'(1);
            2'b10:   ptr_d[c] = ptr_q[c] - ADDR_W'(1);
            2'b11:   if (dsel_rd_q) ptr_d[c] = ptr_q[c] + ADDR_W'(1);
            default: ;
          endcase
        end
      end
      dsel_vld_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge C7M) begin
    if (RES) begin
      phi1r1_q   <= 1'b0;
      phi1r2_q   <= 1'b0;
      regen_q    <= 1'b0;
      ioromen_q  <= 1'b0;
      dsel_vld_q <= 1'b0;
      dsel_ch_q  <= '0;
      dsel_rd_q  <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) ptr_q[c] <= '0;
      mode_q     <= '0;
      bank_q     <= '0;
    end else begin
      phi1r1_q   <= PHI1;
      phi1r2_q   <= phi1r1_q;
      regen_q    <= regen_d;
      ioromen_q  <= ioromen_d;
      dsel_vld_q <= dsel_vld_d;
      dsel_ch_q  <= dsel_ch_d;
      dsel_rd_q  <= dsel_rd_d;
      for (int unsigned c = 0; c < NCH; c++) ptr_q[c] <= ptr_d[c];
      mode_q     <= mode_d;
      bank_q     <= bank_d;
    end
  end

  assign RA        = ~nDEVSEL ? ptr_sel : ra_rom;
  assign nRAMROMCS = datsel | romsel;
  assign RAMCS     = datsel & csdben;
  assign nROMCS    = RAMROMCSgb & csdben & romsel;
  assign RD_out    = D_in;
  assign RD_oe     = ~nWE | (nDEVSEL & nIOSEL & nIOSTRB);
  assign D_oe      = ~RES & csdben & nWE & RAMROMCSgb & (regsel | romsel);
  assign D_out     = (datsel | romsel) ? RD_in : (regsel ? rb : 8'h00);

endmodule

// File: tb/tb_timedisk_ctrl_mc.sv
// Directed bench for timedisk_ctrl_mc: table of bus cycles with
// hand-computed expectations, plus reset and phase-timing sequences.
module tb_timedisk_ctrl_mc;

  logic        C7M, RES, PHI1;
  logic [15:0] A;
  logic        nWE, nDEVSEL, nIOSEL, nIOSTRB;
  logic [7:0]  D_in, D_out, RD_in, RD_out;
  logic        D_oe, RD_oe;
  logic [19:0] RA;
  logic        RAMROMCSgb, nRAMROMCS, RAMCS, nROMCS;

  timedisk_ctrl_mc #(.NCH(2), .ADDR_W(20), .BANK_W(7)) dut (
    .C7M(C7M), .RES(RES), .PHI1(PHI1), .A(A), .nWE(nWE),
    .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB),
    .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
    .RD_in(RD_in), .RD_out(RD_out), .RD_oe(RD_oe), .RA(RA),
    .RAMROMCSgb(RAMROMCSgb), .nRAMROMCS(nRAMROMCS),
    .RAMCS(RAMCS), .nROMCS(nROMCS)
  );

  initial C7M = 1'b0;
  always #5 C7M = ~C7M;

  localparam logic [2:0] DEV = 3'b011;
  localparam logic [2:0] IOS = 3'b101;
  localparam logic [2:0] STB = 3'b110;

  typedef struct {
    logic [15:0] a;
    logic        wen;
    logic [2:0]  sel;
    logic [7:0]  din;
    logic [7:0]  rdin;
    logic [6:0]  chk;   // {ra, dout, doe, ramcs, nromcs, nramromcs, rdoe}
    logic [19:0] ra;
    logic [7:0]  dout;
    logic [4:0]  fl;    // {doe, ramcs, nromcs, nramromcs, rdoe}
  } vec_t;

  vec_t vt[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [19:0] cap_ra;
  logic [7:0]  cap_dout, cap_rdout;
  logic        cap_doe, cap_ramcs, cap_nromcs, cap_nramromcs, cap_rdoe, cap_early_ramcs;

  function automatic vec_t mk(logic [15:0] a, logic wen, logic [2:0] sel, logic [7:0] din,
                              logic [7:0] rdin, logic [6:0] chk, logic [19:0] ra,
                              logic [7:0] dout, logic [4:0] fl);
    vec_t v;
    v.a = a; v.wen = wen; v.sel = sel; v.din = din; v.rdin = rdin;
    v.chk = chk; v.ra = ra; v.dout = dout; v.fl = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One 6502 cycle: phase 1 for 4 C7M edges, then PHI0 with selects asserted.
  // Outputs are captured mid-PHI0, after LATCH and the first WR edge.
  task automatic bus(input logic [15:0] a, input logic wen, input logic [2:0] sel,
                     input logic [7:0] din, input logic [7:0] rdin);
    @(negedge C7M);
    PHI1 = 1'b1; A = a; nWE = wen; D_in = din; RD_in = rdin;
    {nDEVSEL, nIOSEL, nIOSTRB} = 3'b111;
    repeat (3) @(negedge C7M);
    PHI1 = 1'b0;
    {nDEVSEL, nIOSEL, nIOSTRB} = sel;
    @(negedge C7M);
    cap_early_ramcs = RAMCS;
    repeat (2) @(negedge C7M);
    cap_ra = RA; cap_dout = D_out; cap_doe = D_oe; cap_ramcs = RAMCS;
    cap_nromcs = nROMCS; cap_nramromcs = nRAMROMCS; cap_rdoe = RD_oe; cap_rdout = RD_out;
    @(negedge C7M);
  endtask

  initial begin
    RES = 1'b1; PHI1 = 1'b0; A = '0; nWE = 1'b1;
    nDEVSEL = 1'b1; nIOSEL = 1'b1; nIOSTRB = 1'b1;
    D_in = '0; RD_in = 8'hA5; RAMROMCSgb = 1'b1;

    // flags order {doe, ramcs, nromcs, nramromcs, rdoe}
    vt.push_back(mk(16'hC0E3, 1, DEV, 8'h00, 8'hA5, 7'b1011011, 20'h00000, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC812, 1, STB, 8'h00, 8'hA5, 7'b1010110, 20'h00812, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC600, 1, IOS, 8'h00, 8'hA5, 7'b1110111, 20'h00600, 8'hA5, 5'b10110));
    vt.push_back(mk(16'hC812, 1, STB, 8'h00, 8'hA5, 7'b1110110, 20'h00812, 8'hA5, 5'b10110));
    vt.push_back(mk(16'hC0E0, 0, DEV, 8'h34, 8'hA5, 7'b1010001, 20'h00034, 8'h00, 5'b00001));
    vt.push_back(mk(16'hC0E1, 0, DEV, 8'h12, 8'hA5, 7'b1000000, 20'h01234, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC0E2, 0, DEV, 8'h05, 8'hA5, 7'b1000000, 20'h51234, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC0E3, 1, DEV, 8'h00, 8'h5A, 7'b1111111, 20'h51234, 8'h5A, 5'b11010));
    vt.push_back(mk(16'hC0E2, 1, DEV, 8'h00, 8'hA5, 7'b1111000, 20'h51234, 8'hF5, 5'b10000));
    vt.push_back(mk(16'hC0E0, 1, DEV, 8'h00, 8'hA5, 7'b0100000, 20'h00000, 8'h34, 5'b00000));
    vt.push_back(mk(16'hC0E1, 1, DEV, 8'h00, 8'hA5, 7'b0100000, 20'h00000, 8'h12, 5'b00000));
    vt.push_back(mk(16'hC0E4, 0, DEV, 8'hFF, 8'hA5, 7'b0000000, 20'h00000, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC0E5, 0, DEV, 8'hFF, 8'hA5, 7'b0000000, 20'h00000, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC0E6, 0, DEV, 8'h0F, 8'hA5, 7'b1000000, 20'hFFFFF, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC0EC, 0, DEV, 8'h04, 8'hA5, 7'b0000000, 20'h00000, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC0EC, 1, DEV, 8'h00, 8'hA5, 7'b0100000, 20'h00000, 8'h04, 5'b00000));
    vt.push_back(mk(16'hC0E7, 1, DEV, 8'h00, 8'hA5, 7'b1101000, 20'hFFFFF, 8'hA5, 5'b01000));
    vt.push_back(mk(16'hC0E6, 1, DEV, 8'h00, 8'hA5, 7'b1100000, 20'h00000, 8'hF0, 5'b00000));
    vt.push_back(mk(16'hC0E4, 1, DEV, 8'h00, 8'hA5, 7'b0100000, 20'h00000, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC0EC, 0, DEV, 8'h08, 8'hA5, 7'b0000000, 20'h00000, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC0E7, 1, DEV, 8'h00, 8'hA5, 7'b1001000, 20'h00000, 8'h00, 5'b01000));
    vt.push_back(mk(16'hC0E6, 1, DEV, 8'h00, 8'hA5, 7'b1100000, 20'hFFFFF, 8'hFF, 5'b00000));
    vt.push_back(mk(16'hC0EC, 0, DEV, 8'h0C, 8'hA5, 7'b0000000, 20'h00000, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC0E7, 0, DEV, 8'h99, 8'hA5, 7'b1011001, 20'hFFFFF, 8'h00, 5'b01001));
    vt.push_back(mk(16'hC0E7, 1, DEV, 8'h00, 8'hA5, 7'b1001000, 20'hFFFFF, 8'h00, 5'b01000));
    vt.push_back(mk(16'hC0E5, 1, DEV, 8'h00, 8'hA5, 7'b1100000, 20'h00000, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC0EF, 0, DEV, 8'h55, 8'hA5, 7'b0000000, 20'h00000, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC0EF, 1, DEV, 8'h00, 8'hA5, 7'b0110000, 20'h00000, 8'h55, 5'b10000));
    vt.push_back(mk(16'hC0E8, 0, DEV, 8'h77, 8'hA5, 7'b0000000, 20'h00000, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC0E8, 1, DEV, 8'h00, 8'hA5, 7'b0110000, 20'h00000, 8'h00, 5'b10000));
    vt.push_back(mk(16'hC0EC, 1, DEV, 8'h00, 8'hA5, 7'b0100000, 20'h00000, 8'h0C, 5'b00000));
    vt.push_back(mk(16'hC812, 1, STB, 8'h00, 8'hA5, 7'b1110110, 20'h55812, 8'hA5, 5'b10110));
    vt.push_back(mk(16'hCFFF, 1, STB, 8'h00, 8'hA5, 7'b1110110, 20'h55FFF, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC812, 1, STB, 8'h00, 8'hA5, 7'b0010100, 20'h00000, 8'h00, 5'b00000));
    vt.push_back(mk(16'hC600, 1, IOS, 8'h00, 8'hA5, 7'b1000100, 20'h55600, 8'h00, 5'b00100));
    vt.push_back(mk(16'hC812, 1, STB, 8'h00, 8'hA5, 7'b0010100, 20'h00000, 8'h00, 5'b10100));

    // Power-up reset; D_oe must stay low while RES is high even with IOSEL active
    repeat (3) @(negedge C7M);
    nIOSEL = 1'b0;
    #1 check("reset_doe", 32'(D_oe), 32'd0);
    @(negedge C7M);
    RES = 1'b0; nIOSEL = 1'b1;

    foreach (vt[i]) begin
      bus(vt[i].a, vt[i].wen, vt[i].sel, vt[i].din, vt[i].rdin);
      if (vt[i].chk[6]) check($sformatf("v%0d.ra", i),        32'(cap_ra),        32'(vt[i].ra));
      if (vt[i].chk[5]) check($sformatf("v%0d.dout", i),      32'(cap_dout),      32'(vt[i].dout));
      if (vt[i].chk[4]) check($sformatf("v%0d.doe", i),       32'(cap_doe),       32'(vt[i].fl[4]));
      if (vt[i].chk[3]) check($sformatf("v%0d.ramcs", i),     32'(cap_ramcs),     32'(vt[i].fl[3]));
      if (vt[i].chk[2]) check($sformatf("v%0d.nromcs", i),    32'(cap_nromcs),    32'(vt[i].fl[2]));
      if (vt[i].chk[1]) check($sformatf("v%0d.nramromcs", i), 32'(cap_nramromcs), 32'(vt[i].fl[1]));
      if (vt[i].chk[0]) check($sformatf("v%0d.rdoe", i),      32'(cap_rdoe),      32'(vt[i].fl[0]));
      if (vt[i].wen == 1'b0) check($sformatf("v%0d.rdout", i), 32'(cap_rdout), 32'(vt[i].din));
    end

    // RAMCS follows CSDBEN: low early in PHI0, high once CSDBEN rises.
    // ch1 is in read-only step mode at 0, so this read advances it to 1.
    bus(16'hC0E7, 1'b1, DEV, 8'h00, 8'hA5);
    check("ramcs_early", 32'(cap_early_ramcs), 32'd0);
    check("ramcs_late",  32'(cap_ramcs),       32'd1);
    bus(16'hC0E4, 1'b1, DEV, 8'h00, 8'hA5);
    check("ch1_ro_step", 32'(cap_dout), 32'h01);

    // Reset asserted for two cycles in the middle of PHI0 during a register read
    bus(16'hC0E0, 1'b1, DEV, 8'h00, 8'hA5);
    check("pre_rst_doe", 32'(cap_doe), 32'd1);
    RES = 1'b1;
    #1 check("midrst_doe", 32'(D_oe), 32'd0);
    repeat (2) @(negedge C7M);
    RES = 1'b0;
    bus(16'hC0E0, 1'b1, DEV, 8'h00, 8'hA5);
    check("rst_regen_doe", 32'(cap_doe), 32'd0);
    check("rst_ptr0_ra",   32'(cap_ra),  32'h00000);
    bus(16'hC600, 1'b1, IOS, 8'h00, 8'hA5);
    bus(16'hC0E1, 1'b1, DEV, 8'h00, 8'hA5);
    check("rst_ptr0_mid",  32'(cap_dout), 32'h00);
    bus(16'hC0E2, 1'b1, DEV, 8'h00, 8'hA5);
    check("rst_ptr0_hi",   32'(cap_dout), 32'hF0);
    bus(16'hC0E4, 1'b1, DEV, 8'h00, 8'hA5);
    check("rst_ptr1_lo",   32'(cap_dout), 32'h00);
    bus(16'hC0EC, 1'b1, DEV, 8'h00, 8'hA5);
    check("rst_mode",      32'(cap_dout), 32'h00);
    bus(16'hC0EF, 1'b1, DEV, 8'h00, 8'hA5);
    check("rst_bank",      32'(cap_dout), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
